// File: rtl/funct_pkg.sv
// funct_pkg: shared constants for the R-type funct decoder.
//   - funct field encodings (instruction bits [5:0])
//   - 4-bit ALU control codes (zero-extended by the stage to ALU_W)
//   - is_md_or_hilo(): functs that must wait for the MULT/DIV unit
package funct_pkg;

    // funct encodings
    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_SRL     = 6'b000010;
    localparam logic [5:0] F_SRA     = 6'b000011;
    localparam logic [5:0] F_SLLV    = 6'b000100;
    localparam logic [5:0] F_SRLV    = 6'b000110;
    localparam logic [5:0] F_SRAV    = 6'b000111;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_SYSCALL = 6'b001100;
    localparam logic [5:0] F_MFHI    = 6'b010000;
    localparam logic [5:0] F_MFLO    = 6'b010010;
    localparam logic [5:0] F_MULT    = 6'b011000;
    localparam logic [5:0] F_MULTU   = 6'b011001;
    localparam logic [5:0] F_DIV     = 6'b011010;
    localparam logic [5:0] F_DIVU    = 6'b011011;
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUB     = 6'b100010;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_XOR     = 6'b100110;
    localparam logic [5:0] F_NOR     = 6'b100111;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SLTU    = 6'b101011;

    // ALU control codes
    localparam logic [3:0] ALU_NONE  = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0000;
    localparam logic [3:0] ALU_SRL   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_ADD   = 4'b1010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b1110;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_NOR   = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b1101;
    localparam logic [3:0] ALU_SLTU  = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b1001;

    // HI/LO readers and MULT/DIV starters: these stall while the unit is busy
    function automatic logic is_md_or_hilo(input logic [5:0] f);
        case (f)
            F_MFHI, F_MFLO, F_MULT, F_MULTU, F_DIV, F_DIVU: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/funct_lut.sv
// funct_lut: purely combinational funct -> decoded fields.
// Ports:
//   funct      in  6   instruction bits [5:0]
//   alu        out 4   ALU control code (not yet widened)
//   is_jr      out 1   JR
//   is_syscall out 1   SYSCALL
//   is_shamt   out 1   SLL/SRL/SRA (shift by shamt)
//   is_illegal out 1   unrecognised funct
//   is_md      out 1   MULT/MULTU/DIV/DIVU (starts the MULT/DIV unit)
// Build option: FUNCT_EXT_OPS_EN adds SLLV/SRLV/SRAV/XOR; otherwise they are illegal.
module funct_lut
    import funct_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu,
    output logic       is_jr,
    output logic       is_syscall,
    output logic       is_shamt,
    output logic       is_illegal,
    output logic       is_md
);

    // Decode table; anything not listed falls to the illegal default
    always_comb begin
        alu        = ALU_NONE;
        is_jr      = 1'b0;
        is_syscall = 1'b0;
        is_shamt   = 1'b0;
        is_illegal = 1'b0;
        is_md      = 1'b0;
        case (funct)
            F_SLL:          begin alu = ALU_SLL; is_shamt = 1'b1; end
            F_SRL:          begin alu = ALU_SRL; is_shamt = 1'b1; end
            F_SRA:          begin alu = ALU_SRA; is_shamt = 1'b1; end
            F_ADD, F_ADDU:  alu = ALU_ADD;
            F_SUB:          alu = ALU_SUB;
            F_AND:          alu = ALU_AND;
            F_OR:           alu = ALU_OR;
            F_NOR:          alu = ALU_NOR;
            F_SLT:          alu = ALU_SLT;
            F_SLTU:         alu = ALU_SLTU;
            F_JR:           is_jr = 1'b1;
            F_SYSCALL:      is_syscall = 1'b1;
            F_MFHI, F_MFLO: alu = ALU_NONE;
            F_MULT, F_MULTU, F_DIV, F_DIVU: is_md = 1'b1;
`ifdef FUNCT_EXT_OPS_EN
            F_SLLV:         alu = ALU_SLL;
            F_SRLV:         alu = ALU_SRL;
            F_SRAV:         alu = ALU_SRA;
            F_XOR:          alu = ALU_XOR;
`else
            F_SLLV, F_SRLV, F_SRAV, F_XOR: is_illegal = 1'b1;
`endif
            default:        is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/funct_decode_stage.sv
// funct_decode_stage: registered, handshaked R-type funct decoder between the
// ID latch and EX, plus the busy counter that sequences the MULT/DIV unit.
// Parameters: ALU_W (>=4, codes zero-extended), MD_LATENCY (>=1 busy cycles).
// Ports:
//   clk, rst       clock (rising) and synchronous active-high reset
//   in_valid/in_ready/funct      upstream handshake and funct[5:0]
//   out_valid/out_ready          downstream handshake
//   alu, is_jr, is_syscall, is_shamt, is_illegal   registered decoded fields
//   md_start       one-cycle pulse alongside out_valid of an accepted MULT/DIV
//   md_busy        busy counter is nonzero
// Build option: FUNCT_EXT_OPS_EN (see funct_lut) enables SLLV/SRLV/SRAV/XOR.
module funct_decode_stage
    import funct_pkg::*;
#(
    parameter int ALU_W      = 4,
    parameter int MD_LATENCY = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALU_W-1:0] alu,
    output logic             is_jr,
    output logic             is_syscall,
    output logic             is_shamt,
    output logic             is_illegal,
    output logic             md_start,
    output logic             md_busy
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    logic [3:0]       lut_alu_s;
    logic             lut_is_jr_s;
    logic             lut_is_syscall_s;
    logic             lut_is_shamt_s;
    logic             lut_is_illegal_s;
    logic             lut_is_md_s;

    logic             out_valid_r;
    logic [ALU_W-1:0] alu_r;
    logic             is_jr_r;
    logic             is_syscall_r;
    logic             is_shamt_r;
    logic             is_illegal_r;
    logic             md_start_r;
    logic [CNT_W-1:0] md_cnt_r;

    logic             md_busy_s;
    logic             hazard_s;
    logic             accept_s;
    logic             transfer_s;

    funct_lut u_lut (
        .funct      (funct),
        .alu        (lut_alu_s),
        .is_jr      (lut_is_jr_s),
        .is_syscall (lut_is_syscall_s),
        .is_shamt   (lut_is_shamt_s),
        .is_illegal (lut_is_illegal_s),
        .is_md      (lut_is_md_s)
    );

    // The hazard looks only at funct, so in_ready never depends on in_valid
    assign md_busy_s  = (md_cnt_r != {CNT_W{1'b0}});
    assign hazard_s   = md_busy_s && is_md_or_hilo(funct);
    assign in_ready   = (!out_valid_r || out_ready) && !hazard_s;
    assign accept_s   = in_valid && in_ready;
    assign transfer_s = out_valid_r && out_ready;

    // Output register, handshake state and MULT/DIV busy counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            alu_r        <= {ALU_W{1'b0}};
            is_jr_r      <= 1'b0;
            is_syscall_r <= 1'b0;
            is_shamt_r   <= 1'b0;
            is_illegal_r <= 1'b0;
            md_start_r   <= 1'b0;
            md_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                out_valid_r  <= 1'b1;
                alu_r        <= ALU_W'(lut_alu_s);
                is_jr_r      <= lut_is_jr_s;
                is_syscall_r <= lut_is_syscall_s;
                is_shamt_r   <= lut_is_shamt_s;
                is_illegal_r <= lut_is_illegal_s;
            end else if (transfer_s) begin
                // Fields keep their last value; only validity drops
                out_valid_r  <= 1'b0;
            end else begin
                out_valid_r  <= out_valid_r;
            end

            // An MD op can only be accepted when the counter is already 0,
            // so the load never collides with a count in progress
            if (accept_s && lut_is_md_s) begin
                md_cnt_r   <= CNT_W'(MD_LATENCY);
                md_start_r <= 1'b1;
            end else if (md_busy_s) begin
                md_cnt_r   <= md_cnt_r - CNT_W'(1'b1);
                md_start_r <= 1'b0;
            end else begin
                md_cnt_r   <= md_cnt_r;
                md_start_r <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_r;
    assign alu        = alu_r;
    assign is_jr      = is_jr_r;
    assign is_syscall = is_syscall_r;
    assign is_shamt   = is_shamt_r;
    assign is_illegal = is_illegal_r;
    assign md_start   = md_start_r;
    assign md_busy    = md_busy_s;

endmodule

// File: tb/tb_funct_decode_stage.sv
// Bench for funct_decode_stage (ALU_W=4, MD_LATENCY=4): directed steps plus
// randomized traffic against a table-driven reference model.
module tb_funct_decode_stage;

    localparam int MDL = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] funct;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu;
    logic       is_jr;
    logic       is_syscall;
    logic       is_shamt;
    logic       is_illegal;
    logic       md_start;
    logic       md_busy;

    funct_decode_stage #(.ALU_W(4), .MD_LATENCY(MDL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .funct      (funct),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu        (alu),
        .is_jr      (is_jr),
        .is_syscall (is_syscall),
        .is_shamt   (is_shamt),
        .is_illegal (is_illegal),
        .md_start   (md_start),
        .md_busy    (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode table: funct -> {alu, jr, syscall, shamt, md}
    bit [7:0] tab [bit [5:0]];
    bit [5:0] known [$];

    // Reference state
    bit       model_ok;
    bit       m_valid;
    bit [3:0] m_alu;
    bit       m_jr, m_sc, m_sh, m_il, m_start;
    int       m_busy;

    int checks;
    int fails;
    logic last_rdy;
    int start_seen;

    task automatic add(input bit [5:0] f, input bit [3:0] a, input bit jr,
                       input bit sc, input bit sh, input bit md);
        tab[f] = {a, jr, sc, sh, md};
        known.push_back(f);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit stalls_on_md(input bit [5:0] f);
        return f inside {6'b010000, 6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011};
    endfunction

    // One clock: drive, check in_ready, clock, advance model, check outputs
    task automatic cycle(input logic r, input logic iv, input logic [5:0] f, input logic ordy);
        bit exp_rdy;
        bit acc;
        bit [7:0] e;
        rst = r; in_valid = iv; funct = f; out_ready = ordy;
        #1;
        exp_rdy = (!m_valid || ordy) && !(m_busy > 0 && stalls_on_md(f));
        last_rdy = in_ready;
        if (model_ok) chk("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy;
        @(posedge clk);
        #1;
        if (r) begin
            model_ok = 1'b1;
            m_valid = 0; m_alu = 0; m_jr = 0; m_sc = 0; m_sh = 0; m_il = 0;
            m_start = 0; m_busy = 0;
        end else begin
            m_start = 0;
            if (acc) begin
                m_valid = 1;
                if (tab.exists(f)) begin
                    e = tab[f];
                    {m_alu, m_jr, m_sc, m_sh} = e[7:1];
                    m_il = 0;
                end else begin
                    e = 8'h00;
                    {m_alu, m_jr, m_sc, m_sh, m_il} = {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
                end
            end else if (m_valid && ordy) begin
                m_valid = 0;
                e = 8'h00;
            end else begin
                e = 8'h00;
            end
            if (acc && e[0]) begin
                m_busy = MDL;
                m_start = 1;
            end else if (m_busy > 0) begin
                m_busy = m_busy - 1;
            end
        end
        if (model_ok)
            chk("outputs", {out_valid, alu, is_jr, is_syscall, is_shamt, is_illegal, md_start, md_busy},
                {m_valid, m_alu, m_jr, m_sc, m_sh, m_il, m_start, (m_busy > 0)});
        if (md_start === 1'b1) start_seen++;
    endtask

    initial begin
        logic [10:0] snap;
        int stalls;
        bit [5:0] f;
        checks = 0; fails = 0; model_ok = 0; start_seen = 0;
        m_valid = 0; m_busy = 0;

        add(6'b000000, 4'b0000, 0, 0, 1, 0); // SLL
        add(6'b000010, 4'b0100, 0, 0, 1, 0); // SRL
        add(6'b000011, 4'b1000, 0, 0, 1, 0); // SRA
        add(6'b100000, 4'b1010, 0, 0, 0, 0); // ADD
        add(6'b100001, 4'b1010, 0, 0, 0, 0); // ADDU
        add(6'b100010, 4'b0110, 0, 0, 0, 0); // SUB
        add(6'b100100, 4'b1110, 0, 0, 0, 0); // AND
        add(6'b100101, 4'b0001, 0, 0, 0, 0); // OR
        add(6'b100111, 4'b0101, 0, 0, 0, 0); // NOR
        add(6'b101010, 4'b1101, 0, 0, 0, 0); // SLT
        add(6'b101011, 4'b0011, 0, 0, 0, 0); // SLTU
        add(6'b001000, 4'b0000, 1, 0, 0, 0); // JR
        add(6'b001100, 4'b0000, 0, 1, 0, 0); // SYSCALL
        add(6'b010000, 4'b0000, 0, 0, 0, 0); // MFHI
        add(6'b010010, 4'b0000, 0, 0, 0, 0); // MFLO
        add(6'b011000, 4'b0000, 0, 0, 0, 1); // MULT
        add(6'b011001, 4'b0000, 0, 0, 0, 1); // MULTU
        add(6'b011010, 4'b0000, 0, 0, 0, 1); // DIV
        add(6'b011011, 4'b0000, 0, 0, 0, 1); // DIVU
`ifdef FUNCT_EXT_OPS_EN
        add(6'b000100, 4'b0000, 0, 0, 0, 0); // SLLV
        add(6'b000110, 4'b0100, 0, 0, 0, 0); // SRLV
        add(6'b000111, 4'b1000, 0, 0, 0, 0); // SRAV
        add(6'b100110, 4'b1001, 0, 0, 0, 0); // XOR
`endif

        // Reset
        cycle(1'b1, 1'b0, 6'b000000, 1'b1);
        cycle(1'b1, 1'b0, 6'b000000, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_md_busy", md_busy, 1'b0);

        // ADD, one-cycle latency
        cycle(1'b0, 1'b1, 6'b100000, 1'b1);
        chk("add_ready", last_rdy, 1'b1);
        chk("add_alu", {out_valid, alu}, 5'b1_1010);

        // Sweep of base functs
        for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, known[i], 1'b1);
        cycle(1'b0, 1'b1, 6'b001000, 1'b1);
        chk("jr_flag", is_jr, 1'b1);
        cycle(1'b0, 1'b1, 6'b001100, 1'b1);
        chk("syscall_flag", is_syscall, 1'b1);
        cycle(1'b0, 1'b1, 6'b000011, 1'b1);
        chk("sra_fields", {is_shamt, alu}, 5'b1_1000);

        // MULT then MFHI held until accepted
        start_seen = 0;
        cycle(1'b0, 1'b1, 6'b011000, 1'b1);
        chk("mult_start", md_start, 1'b1);
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b1, 6'b010000, 1'b1);
            if (last_rdy === 1'b1) break;
            stalls++;
        end
        chk("mfhi_stall_cycles", stalls, MDL);
        chk("md_start_pulses", start_seen, 1);
        chk("mfhi_accepted", {out_valid, md_busy}, 2'b10);

        // Backpressure
        cycle(1'b0, 1'b1, 6'b100100, 1'b1);
        snap = {out_valid, alu, is_jr, is_syscall, is_shamt, is_illegal, md_start, md_busy};
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, 6'b100010, 1'b0);
            chk("bp_ready_low", last_rdy, 1'b0);
            chk("bp_hold", {out_valid, alu, is_jr, is_syscall, is_shamt, is_illegal, md_start, md_busy}, snap);
        end
        cycle(1'b0, 1'b1, 6'b100010, 1'b1);
        chk("bp_release_accept", last_rdy, 1'b1);
        chk("bp_new_alu", {out_valid, alu}, 5'b1_0110);

        // XOR funct, build dependent
        cycle(1'b0, 1'b1, 6'b100110, 1'b1);
`ifdef FUNCT_EXT_OPS_EN
        chk("xor_decode", {is_illegal, alu}, 5'b0_1001);
`else
        chk("xor_decode", {is_illegal, alu}, 5'b1_0000);
`endif

        // Reset during a busy count of 2, then DIV accepted at once
        cycle(1'b0, 1'b1, 6'b011010, 1'b1);
        cycle(1'b0, 1'b0, 6'b000000, 1'b1);
        cycle(1'b0, 1'b0, 6'b000000, 1'b1);
        cycle(1'b1, 1'b1, 6'b011011, 1'b1);
        chk("rst_mid_busy", {md_busy, out_valid}, 2'b00);
        cycle(1'b0, 1'b1, 6'b011010, 1'b1);
        chk("div_after_rst", {last_rdy, md_start}, 2'b11);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(9, 0) < 8) f = known[$urandom_range(known.size() - 1, 0)];
            else f = 6'($urandom());
            cycle(($urandom_range(99, 0) == 0), ($urandom_range(3, 0) != 0), f,
                  ($urandom_range(9, 0) < 7));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
